// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencer for the Beta core: fetches one instruction, classifies it and
// steps the PC exactly once. Optional fetch timeout fault is built under IMEM_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  input  logic             operand_valid,
  output logic             pc_clk_en,
  output logic [1:0]       pc_sel,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic             fault,
  output logic [2:0]       dbg_state
);

  // Handshake: imem_req is held high through every FETCH cycle; the cycle that
  // sees imem_req && imem_ack transfers imem_rdata, including the first one.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_RESOLVE = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;

  state_t     state;
  state_t     state_nx;
  logic       halt_pending;
  logic [5:0] opcode;
  logic [1:0] dec_sel;
  logic       timeout_hit;
  logic       stop_now;

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("fetch_sequencer: TIMEOUT must be at least 1");
  end

`ifdef IMEM_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Cleared whenever outside FETCH, so each fetch starts counting from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state != S_FETCH) begin
      wait_cnt <= '0;
    end else if (!imem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == S_FETCH) && !imem_ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign fault       = (state == S_FAULT);
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  assign opcode = instr_out[31:26];

  always_comb begin
    dec_sel = 2'b00;
    case (opcode)
      OP_BEQ:  dec_sel = 2'b01;
      OP_JMP:  dec_sel = 2'b10;
      OP_BNE:  dec_sel = 2'b11;
      default: dec_sel = 2'b00;
    endcase
  end

  assign stop_now  = halt_pending || halt_req;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_clk_en   = 1'b0;
    pc_sel      = 2'b00;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)         state_nx = S_DECODE;
        else if (timeout_hit) state_nx = S_FAULT;
      end
      S_DECODE: begin
        instr_valid = 1'b1;
        if (dec_sel != 2'b00) begin
          state_nx = S_RESOLVE;
        end else begin
          pc_clk_en = 1'b1;
          state_nx  = stop_now ? S_IDLE : S_FETCH;
        end
      end
      S_RESOLVE: begin
        pc_sel    = dec_sel;
        pc_clk_en = operand_valid;
        if (operand_valid) state_nx = stop_now ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        state_nx = S_FAULT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      instr_out    <= '0;
      retired      <= '0;
      halt_pending <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack) instr_out <= imem_rdata;
      if (pc_clk_en) retired <= retired + 1'b1;
      // A halt only takes effect at an instruction boundary, which also consumes it.
      if (pc_clk_en)                          halt_pending <= 1'b0;
      else if (state != S_IDLE && halt_req)   halt_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed instruction sequences plus a transaction-level
// model that checks instruction delivery, PC stepping and the retired count every cycle.
module tb_fetch_sequencer;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             halt_req;
  logic             imem_req;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic [31:0]      instr_out;
  logic             instr_valid;
  logic             operand_valid;
  logic             pc_clk_en;
  logic [1:0]       pc_sel;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic             fault;
  logic [2:0]       dbg_state;

  fetch_sequencer #(.TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .halt_req      (halt_req),
    .imem_req      (imem_req),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .operand_valid (operand_valid),
    .pc_clk_en     (pc_clk_en),
    .pc_sel        (pc_sel),
    .busy          (busy),
    .retired       (retired),
    .fault         (fault),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_retired;
  logic        awaiting;
  logic [1:0]  cur_code;
  logic        m_en;
  logic [1:0]  m_sel;
  logic [31:0] m_exp;

  task automatic chkv(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // Beta control-flow opcodes select the PC source; everything else steps normally.
  function automatic logic [1:0] classify(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'h1C)      return 2'b01;
    else if (op == 6'h1D) return 2'b11;
    else if (op == 6'h1B) return 2'b10;
    else                  return 2'b00;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #3;
  endtask

  // Entry: just after the edge that entered FETCH. Exit: mid-cycle after the boundary.
  task automatic do_instr(input logic [31:0] rdata, input int ack_delay, input int op_delay,
                          input int halt_mode, input logic [1:0] exp_sel, input logic exp_idle);
    halt_req = (halt_mode == 1);
    for (int i = 0; i < ack_delay; i++) begin
      mid;
      chk1("fetch_wait_req", imem_req, 1'b1);
      chk1("fetch_wait_valid", instr_valid, 1'b0);
      tick;
      halt_req = 1'b0;
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    exp_q.push_back(rdata);
    mid;
    chk1("fetch_ack_req", imem_req, 1'b1);
    tick;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    halt_req   = (halt_mode == 2) && (exp_sel == 2'b00);
    mid;
    chk1("dec_valid", instr_valid, 1'b1);
    chkv("dec_instr", instr_out, rdata);
    chk1("dec_en", pc_clk_en, exp_sel == 2'b00);
    chkv("dec_sel", {30'd0, pc_sel}, 32'd0);
    if (exp_sel != 2'b00) begin
      for (int i = 0; i < op_delay; i++) begin
        tick;
        operand_valid = 1'b0;
        mid;
        chk1("res_wait_en", pc_clk_en, 1'b0);
        chkv("res_wait_sel", {30'd0, pc_sel}, {30'd0, exp_sel});
        chk1("res_wait_req", imem_req, 1'b0);
      end
      tick;
      operand_valid = 1'b1;
      halt_req      = (halt_mode == 2);
      mid;
      chk1("res_en", pc_clk_en, 1'b1);
      chkv("res_sel", {30'd0, pc_sel}, {30'd0, exp_sel});
      chk1("res_valid", instr_valid, 1'b0);
    end
    tick;
    operand_valid = 1'b0;
    halt_req      = 1'b0;
    mid;
    chk1("end_busy", busy, !exp_idle);
    chk1("end_req", imem_req, !exp_idle);
  endtask

  // scoreboard: every instruction handed to the core must appear once and step the PC once
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      awaiting      = 1'b0;
      cur_code      = 2'b00;
      model_retired = '0;
    end else begin
      chkv("m_retired", retired, model_retired);
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL m_instr_unexpected: got instr_valid with 0x%08h expected no delivery at %0t",
                   instr_out, $time);
          cur_code = 2'b00;
        end else begin
          m_exp = exp_q.pop_front();
          chkv("m_instr", instr_out, m_exp);
          cur_code = classify(m_exp);
        end
        m_en     = (cur_code == 2'b00);
        m_sel    = 2'b00;
        awaiting = (cur_code != 2'b00);
        chk1("m_req_decode", imem_req, 1'b0);
      end else if (awaiting) begin
        m_en  = operand_valid;
        m_sel = cur_code;
        chk1("m_req_resolve", imem_req, 1'b0);
        if (operand_valid) awaiting = 1'b0;
      end else begin
        m_en  = 1'b0;
        m_sel = 2'b00;
      end
      chk1("m_pc_clk_en", pc_clk_en, m_en);
      chkv("m_pc_sel", {30'd0, pc_sel}, {30'd0, m_sel});
`ifndef IMEM_TIMEOUT_EN
      chk1("m_fault_tied", fault, 1'b0);
`endif
      if (m_en) model_retired = model_retired + 1;
    end
  end

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    halt_req      = 1'b0;
    imem_ack      = 1'b0;
    imem_rdata    = '0;
    operand_valid = 1'b0;
    #2;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_en", pc_clk_en, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    chkv("rst_sel", {30'd0, pc_sel}, 32'd0);
    chkv("rst_instr", instr_out, 32'd0);
    chkv("rst_retired", retired, 32'd0);
    tick;
    tick;
    rst = 1'b0;

    // halt in IDLE is ignored; start with halt still fetches
    halt_req = 1'b1;
    tick;
    halt_req = 1'b0;
    mid;
    chk1("idle_halt_busy", busy, 1'b0);
    chk1("idle_halt_req", imem_req, 1'b0);
    start    = 1'b1;
    halt_req = 1'b1;
    tick;
    start    = 1'b0;
    halt_req = 1'b0;

    do_instr(32'h8000_0000, 2, 0, 0, 2'b00, 1'b0);
    chkv("t1_retired", retired, 32'd1);
    do_instr(32'h73FF_0004, 0, 3, 0, 2'b01, 1'b0);
    chkv("beq_retired", retired, 32'd2);
    do_instr(32'h77E0_0002, 0, 0, 0, 2'b11, 1'b0);
    do_instr(32'h6FE0_0000, 1, 0, 0, 2'b10, 1'b0);
    do_instr(32'h0000_0000, 0, 0, 0, 2'b00, 1'b0);
    do_instr(32'hFC00_0000, 0, 0, 0, 2'b00, 1'b0);

    // halt mid-FETCH: instruction completes, then stays idle without start
    do_instr(32'h8000_0000, 2, 0, 1, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick;
      mid;
      chk1("halted_req", imem_req, 1'b0);
      chk1("halted_busy", busy, 1'b0);
    end
    chkv("halt_retired", retired, 32'd7);

    // halt raised in the branch's own boundary cycle
    start = 1'b1;
    tick;
    start = 1'b0;
    do_instr(32'h73FF_0004, 0, 1, 2, 2'b01, 1'b1);
    chkv("bhalt_retired", retired, 32'd8);

    // reset during FETCH with an ack in flight
    start = 1'b1;
    tick;
    start = 1'b0;
    mid;
    chk1("pre_rst_req", imem_req, 1'b1);
    tick;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    rst        = 1'b1;
    #1;
    chk1("mrst_req", imem_req, 1'b0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_en", pc_clk_en, 1'b0);
    chk1("mrst_valid", instr_valid, 1'b0);
    chkv("mrst_sel", {30'd0, pc_sel}, 32'd0);
    chkv("mrst_retired", retired, 32'd0);
    chkv("mrst_instr", instr_out, 32'd0);
    tick;
    imem_ack = 1'b0;
    rst      = 1'b0;
    mid;
    chkv("post_rst_instr", instr_out, 32'd0);
    chk1("post_rst_busy", busy, 1'b0);

    start = 1'b1;
    tick;
    start = 1'b0;
    do_instr(32'h8000_0000, 0, 0, 2, 2'b00, 1'b1);
    chkv("recover_retired", retired, 32'd1);

`ifdef IMEM_TIMEOUT_EN
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      mid;
      chk1("to_wait_req", imem_req, 1'b1);
      chk1("to_wait_fault", fault, 1'b0);
      tick;
    end
    mid;
    chk1("to_fault", fault, 1'b1);
    chk1("to_req", imem_req, 1'b0);
    chk1("to_busy", busy, 1'b1);
    imem_ack = 1'b1;
    tick;
    tick;
    imem_ack = 1'b0;
    mid;
    chk1("to_sticky", fault, 1'b1);
    chk1("to_sticky_busy", busy, 1'b1);
    tick;
    rst = 1'b1;
    #1;
    chk1("to_rst_fault", fault, 1'b0);
    tick;
    rst   = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    do_instr(32'h8000_0000, 14, 0, 2, 2'b00, 1'b1);
    chk1("to_ack15_fault", fault, 1'b0);
`endif

    tick;
    tick;
    chkv("sb_empty", 32'(exp_q.size()), 32'd0);
    chk1("sb_no_branch_open", awaiting, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
